// File: rtl/stopwatch_timebase.sv
// Stopwatch timebase: button synchronisers, 1 Hz prescaler, idle/run/pause FSM and MM:SS counter
// with sticky overflow. Define STOPWATCH_LAP_EN to add the lap (display freeze) feature.
module stopwatch_timebase #(
    parameter int unsigned CLK_HZ   = 50_000_000,
    parameter int unsigned TICK_DIV = CLK_HZ,
    parameter int unsigned MAX_MIN  = 59
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       btn_start,
    input  logic       btn_clear,
    input  logic       btn_lap,
    output logic [6:0] minutes,
    output logic [6:0] seconds,
    output logic       running,
    output logic       overflow
);
    localparam int unsigned PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [6:0] MIN_LAST = 7'(MAX_MIN);
    localparam logic [6:0] SEC_LAST = 7'd59;

    if (CLK_HZ == 0 || TICK_DIV < 2 || MAX_MIN > 99) begin : g_param_check
        $error("stopwatch_timebase: illegal parameter value");
    end

`ifdef STOPWATCH_LAP_EN
    localparam int unsigned NB = 3;
    logic [NB-1:0] w_btn_raw;
    assign w_btn_raw = {btn_lap, btn_clear, btn_start};
`else
    localparam int unsigned NB = 2;
    logic [NB-1:0] w_btn_raw;
    logic          w_unused_lap;
    assign w_btn_raw    = {btn_clear, btn_start};
    assign w_unused_lap = btn_lap;
`endif

    logic [NB-1:0] r_btn_meta;
    logic [NB-1:0] r_btn_sync;
    logic [NB-1:0] r_btn_prev;
    logic [NB-1:0] w_btn_pulse;
    logic          w_start_p;
    logic          w_clear_p;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_btn_meta <= '0;
            r_btn_sync <= '0;
            r_btn_prev <= '0;
        end else begin
            r_btn_meta <= w_btn_raw;
            r_btn_sync <= r_btn_meta;
            r_btn_prev <= r_btn_sync;
        end
    end

    // One-clock pulse on each synchronised rising edge; a held button gives a single pulse.
    assign w_btn_pulse = r_btn_sync & ~r_btn_prev;
    assign w_start_p   = w_btn_pulse[0];
    assign w_clear_p   = w_btn_pulse[1];

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StPause = 2'd2
    } state_e;

    state_e r_state;
    state_e w_state_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        if (w_clear_p) begin
            w_state_d = StIdle;
        end else if (w_start_p) begin
            case (r_state)
                StIdle:  w_state_d = StRun;
                StRun:   w_state_d = StPause;
                StPause: w_state_d = StRun;
                default: w_state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        running = (r_state == StRun);
    end

    logic [PW-1:0] r_presc;
    logic [6:0]    r_min;
    logic [6:0]    r_sec;
    logic          r_overflow;
    logic          w_tick;

    assign w_tick = (r_state == StRun) && (r_presc == PRESC_LAST);

    // The prescaler only advances in RUN, so a paused fraction of a second survives resume.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_presc    <= '0;
            r_min      <= '0;
            r_sec      <= '0;
            r_overflow <= 1'b0;
        end else if (w_clear_p) begin
            r_presc    <= '0;
            r_min      <= '0;
            r_sec      <= '0;
            r_overflow <= 1'b0;
        end else if (r_state == StRun) begin
            if (w_tick) begin
                r_presc <= '0;
                if (r_sec == SEC_LAST) begin
                    r_sec <= '0;
                    if (r_min == MIN_LAST) begin
                        r_min      <= '0;
                        r_overflow <= 1'b1;
                    end else begin
                        r_min <= r_min + 7'd1;
                    end
                end else begin
                    r_sec <= r_sec + 7'd1;
                end
            end else begin
                r_presc <= r_presc + 1'b1;
            end
        end
    end

    assign overflow = r_overflow;

`ifdef STOPWATCH_LAP_EN
    logic       r_frozen;
    logic [6:0] r_snap_min;
    logic [6:0] r_snap_sec;
    logic       w_lap_p;

    assign w_lap_p = w_btn_pulse[2];

    // Snapshot holds the time displayed at the lap edge; live counting is untouched.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_frozen   <= 1'b0;
            r_snap_min <= '0;
            r_snap_sec <= '0;
        end else if (w_clear_p) begin
            r_frozen <= 1'b0;
        end else if (w_lap_p && (r_state != StIdle)) begin
            r_frozen <= ~r_frozen;
            if (!r_frozen) begin
                r_snap_min <= r_min;
                r_snap_sec <= r_sec;
            end
        end
    end

    assign minutes = r_frozen ? r_snap_min : r_min;
    assign seconds = r_frozen ? r_snap_sec : r_sec;
`else
    assign minutes = r_min;
    assign seconds = r_sec;
`endif

endmodule

// File: tb/tb_stopwatch_timebase.sv
// Self-checking bench for stopwatch_timebase with TICK_DIV=4 and a time-based reference model.
// Lap checks are compiled in when STOPWATCH_LAP_EN is defined.
module tb_stopwatch_timebase;
    localparam int unsigned TICK_DIV = 4;
    localparam int unsigned MAX_MIN  = 59;
    localparam int          PERIOD   = (MAX_MIN + 1) * 60;
`ifdef STOPWATCH_LAP_EN
    localparam bit LAP_ON = 1'b1;
`else
    localparam bit LAP_ON = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       btn_start = 1'b0;
    logic       btn_clear = 1'b0;
    logic       btn_lap = 1'b0;
    logic [6:0] minutes;
    logic [6:0] seconds;
    logic       running;
    logic       overflow;

    stopwatch_timebase #(
        .CLK_HZ  (1000),
        .TICK_DIV(TICK_DIV),
        .MAX_MIN (MAX_MIN)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .btn_start(btn_start),
        .btn_clear(btn_clear),
        .btn_lap  (btn_lap),
        .minutes  (minutes),
        .seconds  (seconds),
        .running  (running),
        .overflow (overflow)
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: mode 0=idle 1=run 2=pause; time derives from total clocks spent running.
    int       m_mode   = 0;
    int       m_run    = 0;
    bit       m_frozen = 1'b0;
    int       m_snap   = 0;
    logic [2:0] h_start = '0;
    logic [2:0] h_clear = '0;
    logic [2:0] h_lap   = '0;

    function automatic int m_ticks();
        return m_run / TICK_DIV;
    endfunction

    function automatic logic [15:0] exp_vec();
        int t;
        int d;
        t = m_run / TICK_DIV;
        d = m_frozen ? m_snap : (t % PERIOD);
        return {7'(d / 60), 7'(d % 60), (m_mode == 1), (t >= PERIOD)};
    endfunction

    function automatic logic [15:0] got_vec();
        return {minutes, seconds, running, overflow};
    endfunction

    task automatic reset_model();
        m_mode   = 0;
        m_run    = 0;
        m_frozen = 1'b0;
        m_snap   = 0;
        h_start  = '0;
        h_clear  = '0;
        h_lap    = '0;
    endtask

    // Advance one clock; a button counts as pressed 3 samples after its level rises.
    task automatic step();
        bit p_s;
        bit p_c;
        bit p_l;
        int t;
        @(posedge clock);
        p_s = h_start[1] & ~h_start[2];
        p_c = h_clear[1] & ~h_clear[2];
        p_l = h_lap[1] & ~h_lap[2];
        t   = (m_run / TICK_DIV) % PERIOD;
        if (p_c) begin
            m_mode   = 0;
            m_run    = 0;
            m_frozen = 1'b0;
        end else begin
            if (LAP_ON && p_l && m_mode != 0) begin
                if (!m_frozen) m_snap = t;
                m_frozen = !m_frozen;
            end
            if (m_mode == 1) m_run++;
            if (p_s) m_mode = (m_mode == 1) ? 2 : 1;
        end
        h_start = {h_start[1:0], btn_start};
        h_clear = {h_clear[1:0], btn_clear};
        h_lap   = {h_lap[1:0], btn_lap};
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #12;
        n_tests++;
        if (got_vec() !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_state: got %h want %h", got_vec(), 16'h0);
        end
        @(negedge clock);
        reset = 1'b0;
        reset_model();
        for (int i = 0; i < 4; i++) step();
    endtask

    task automatic test_start_count();
        for (int i = 1; i <= 23; i++) begin
            btn_start = (i <= 2);
            step();
            n_tests++;
            if (got_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL start_model[%0d]: got %h want %h", i, got_vec(), exp_vec());
            end
            if (i == 3) begin
                n_tests++;
                if (running !== 1'b1 || seconds !== 7'd0) begin
                    n_fail++;
                    $display("FAIL start_running: got run=%b s=%0d want run=1 s=0", running, seconds);
                end
            end
            if (i == 7 || i == 23) begin
                n_tests++;
                if (seconds !== ((i == 7) ? 7'd1 : 7'd5)) begin
                    n_fail++;
                    $display("FAIL start_seconds[%0d]: got %0d want %0d", i, seconds,
                             (i == 7) ? 1 : 5);
                end
            end
        end
    endtask

    task automatic test_minute_wrap();
        int guard;
        guard = 0;
        while (m_ticks() < 59 && guard < 400) begin
            step();
            guard++;
            n_tests++;
            if (got_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL wrap_model: got %h want %h", got_vec(), exp_vec());
            end
        end
        n_tests++;
        if (minutes !== 7'd0 || seconds !== 7'd59) begin
            n_fail++;
            $display("FAIL wrap_0059: got %0d:%0d want 0:59", minutes, seconds);
        end
        for (int i = 0; i < TICK_DIV; i++) step();
        n_tests++;
        if (minutes !== 7'd1 || seconds !== 7'd0 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_0100: got %0d:%0d ovf=%b want 1:0 ovf=0", minutes, seconds,
                     overflow);
        end
    endtask

    task automatic test_overflow();
        int guard;
        guard = 0;
        while (m_ticks() < PERIOD - 1 && guard < 20000) begin
            step();
            guard++;
            n_tests++;
            if (got_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL ovf_model: got %h want %h", got_vec(), exp_vec());
            end
        end
        n_tests++;
        if (minutes !== 7'd59 || seconds !== 7'd59 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_5959: got %0d:%0d ovf=%b want 59:59 ovf=0", minutes, seconds,
                     overflow);
        end
        for (int i = 0; i < TICK_DIV; i++) step();
        n_tests++;
        if (minutes !== 7'd0 || seconds !== 7'd0 || overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_wrap: got %0d:%0d ovf=%b want 0:0 ovf=1", minutes, seconds,
                     overflow);
        end
        for (int i = 0; i < 10 * TICK_DIV; i++) step();
        n_tests++;
        if (seconds !== 7'd10 || overflow !== 1'b1 || running !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_sticky: got s=%0d ovf=%b run=%b want s=10 ovf=1 run=1", seconds,
                     overflow, running);
        end
        btn_clear = 1'b1;
        for (int i = 0; i < 3; i++) step();
        btn_clear = 1'b0;
        n_tests++;
        if (got_vec() !== 16'h0) begin
            n_fail++;
            $display("FAIL ovf_clear: got %h want %h", got_vec(), 16'h0);
        end
        for (int i = 0; i < 4; i++) step();
    endtask

    task automatic test_pause_resume();
        logic [16:0] pat;
        pat = 17'b0_0001_0000_0000_0101;
        for (int i = 1; i <= 17; i++) begin
            btn_start = pat[i-1];
            step();
            n_tests++;
            if (got_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL pause_model[%0d]: got %h want %h", i, got_vec(), exp_vec());
            end
            if (i == 5 || i == 14) begin
                n_tests++;
                if (running !== 1'b0 || seconds !== 7'd0) begin
                    n_fail++;
                    $display("FAIL pause_hold[%0d]: got run=%b s=%0d want run=0 s=0", i, running,
                             seconds);
                end
            end
            if (i == 16 || i == 17) begin
                n_tests++;
                if (running !== 1'b1 || seconds !== ((i == 17) ? 7'd1 : 7'd0)) begin
                    n_fail++;
                    $display("FAIL pause_resume[%0d]: got run=%b s=%0d want run=1 s=%0d", i,
                             running, seconds, (i == 17) ? 1 : 0);
                end
            end
        end
        btn_start = 1'b0;
    endtask

    task automatic test_start_clear_same();
        int guard;
        btn_clear = 1'b1;
        step();
        btn_clear = 1'b0;
        for (int i = 0; i < 4; i++) step();
        btn_start = 1'b1;
        step();
        btn_start = 1'b0;
        guard = 0;
        while (m_ticks() < 7 && guard < 100) begin
            step();
            guard++;
        end
        n_tests++;
        if (seconds !== 7'd7 || running !== 1'b1) begin
            n_fail++;
            $display("FAIL same_pre: got s=%0d run=%b want s=7 run=1", seconds, running);
        end
        btn_start = 1'b1;
        btn_clear = 1'b1;
        for (int i = 0; i < 3; i++) step();
        n_tests++;
        if (got_vec() !== 16'h0) begin
            n_fail++;
            $display("FAIL same_clear: got %h want %h", got_vec(), 16'h0);
        end
        for (int i = 0; i < 8; i++) step();
        n_tests++;
        if (got_vec() !== 16'h0) begin
            n_fail++;
            $display("FAIL same_held: got %h want %h", got_vec(), 16'h0);
        end
        btn_start = 1'b0;
        btn_clear = 1'b0;
        for (int i = 0; i < 4; i++) step();
    endtask

    task automatic test_lap();
        int guard;
        btn_start = 1'b1;
        step();
        btn_start = 1'b0;
        while (m_mode != 1) step();
        guard = 0;
        while (m_run < 24 && guard < 100) begin
            btn_lap = (m_run == 11 || m_run == 19);
            step();
            guard++;
            n_tests++;
            if (got_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL lap_model: got %h want %h", got_vec(), exp_vec());
            end
            if (LAP_ON && m_run >= 14 && m_run <= 21) begin
                n_tests++;
                if (minutes !== 7'd0 || seconds !== 7'd3) begin
                    n_fail++;
                    $display("FAIL lap_freeze[%0d]: got %0d:%0d want 0:3", m_run, minutes,
                             seconds);
                end
            end
            if (LAP_ON && m_run == 22) begin
                n_tests++;
                if (minutes !== 7'd0 || seconds !== 7'd5) begin
                    n_fail++;
                    $display("FAIL lap_release: got %0d:%0d want 0:5", minutes, seconds);
                end
            end
        end
        btn_lap = 1'b0;
        btn_clear = 1'b1;
        step();
        btn_clear = 1'b0;
        for (int i = 0; i < 6; i++) begin
            btn_lap = (i == 0);
            step();
            n_tests++;
            if (got_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL lap_idle[%0d]: got %h want %h", i, got_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 5) == 0) btn_start = ~btn_start;
            if ($urandom_range(0, 60) == 0) btn_clear = ~btn_clear;
            if ($urandom_range(0, 9) == 0) btn_lap = ~btn_lap;
            step();
            n_tests++;
            if (got_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL random[%0d]: got %h want %h", i, got_vec(), exp_vec());
            end
        end
        btn_start = 1'b0;
        btn_clear = 1'b0;
        btn_lap   = 1'b0;
    endtask

    task automatic test_mid_reset();
        btn_start = 1'b1;
        step();
        btn_start = 1'b0;
        for (int i = 0; i < 4 * TICK_DIV + 2; i++) step();
        n_tests++;
        if (got_vec() !== exp_vec() || seconds == 7'd0) begin
            n_fail++;
            $display("FAIL midrst_pre: got %h want %h", got_vec(), exp_vec());
        end
        #2;
        reset = 1'b1;
        #1;
        n_tests++;
        if (got_vec() !== 16'h0) begin
            n_fail++;
            $display("FAIL midrst_async: got %h want %h", got_vec(), 16'h0);
        end
        reset_model();
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 3 * TICK_DIV; i++) begin
            step();
            n_tests++;
            if (got_vec() !== 16'h0) begin
                n_fail++;
                $display("FAIL midrst_idle[%0d]: got %h want %h", i, got_vec(), 16'h0);
            end
        end
    endtask

    initial begin
        test_reset();
        test_start_count();
        test_minute_wrap();
        test_overflow();
        test_pause_resume();
        test_start_clear_same();
        test_lap();
        test_random();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
